proc_instr_feeder: RTL and testbench

//  Instruction sequencer that drives the Run/Din side of the proc Run/Done handshake.

---
 rtl/proc_instr_feeder.sv | 148 ++++++++++++++
 tb/tb_proc_instr_feeder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_instr_feeder.sv
// Program sequencer for the proc Run/Done handshake: issues stored 16-bit words one at a
// time on Din with Run, waiting for Done between words.
module proc_instr_feeder #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic          CLOCK_50,
    input  logic          Rest,
    input  logic          Start,
    input  logic          Stop,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_data,
    input  logic [AW:0]   prog_len,
    input  logic          Done,
    output logic [15:0]   Din,
    output logic          Run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          finished,
    output logic          timeout_err,
    output logic [15:0]   instr_count
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t        state_q;
    logic [AW:0]   pc_q;
    logic [AW:0]   len_q;
    logic [TW-1:0] wait_q;
    logic [GW-1:0] gap_q;
    logic          stop_pend_q;
    logic [AW:0]   len_c;
    logic [15:0]   mem [DEPTH];

    // pc_q carries one extra bit so a full DEPTH-word program can be told apart from an empty one
    assign pc    = pc_q[AW-1:0];
    assign len_c = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;

    // Program memory: loadable only while no program is running
    always_ff @(posedge CLOCK_50) begin
        if (ld_en && (state_q != S_ISSUE) && (state_q != S_GAP)) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Rest) begin
        if (!Rest) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            wait_q      <= '0;
            gap_q       <= '0;
            stop_pend_q <= 1'b0;
            Din         <= '0;
            Run         <= 1'b0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            timeout_err <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (Stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (Done) begin
                        state_q <= S_GAP;
                        Run     <= 1'b0;
                        gap_q   <= '0;
                        pc_q    <= pc_q + (AW+1)'(1);
                        if (instr_count != 16'hFFFF) begin
                            instr_count <= instr_count + 16'd1;
                        end
                    end else if (wait_q == TW'(TIMEOUT - 1)) begin
                        state_q     <= S_ERROR;
                        Run         <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
                end

                S_GAP: begin
                    if (Stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        if (stop_pend_q || Stop) begin
                            state_q <= S_IDLE;
                            busy    <= 1'b0;
                        end else if (pc_q == len_q) begin
                            state_q  <= S_FINISH;
                            busy     <= 1'b0;
                            finished <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            Run     <= 1'b1;
                            Din     <= mem[pc_q[AW-1:0]];
                            wait_q  <= '0;
                        end
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end

                default: begin
                    // Idle-like states: Stop beats Start when both arrive together
                    if (Stop) begin
                        state_q     <= S_IDLE;
                        finished    <= 1'b0;
                        timeout_err <= 1'b0;
                    end else if (Start) begin
                        len_q       <= len_c;
                        pc_q        <= '0;
                        instr_count <= '0;
                        timeout_err <= 1'b0;
                        stop_pend_q <= 1'b0;
                        wait_q      <= '0;
                        if (len_c == '0) begin
                            state_q  <= S_FINISH;
                            finished <= 1'b1;
                        end else begin
                            state_q  <= S_ISSUE;
                            finished <= 1'b0;
                            busy     <= 1'b1;
                            Run      <= 1'b1;
                            Din      <= mem[0];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_instr_feeder.sv
// Directed bench for proc_instr_feeder: a proc stub answers Run with Done, and a scoreboard
// compares each accepted Din against the words expected for the program being run.
module tb_proc_instr_feeder;

    logic        clk;
    logic        rst_n;
    logic        start, stop, ld_en;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic [4:0]  prog_len;
    logic        done;
    logic [15:0] din;
    logic        run;
    logic [3:0]  pc;
    logic        busy, finished, timeout_err;
    logic [15:0] instr_count;

    proc_instr_feeder dut (
        .CLOCK_50    (clk),
        .Rest        (rst_n),
        .Start       (start),
        .Stop        (stop),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .prog_len    (prog_len),
        .Done        (done),
        .Din         (din),
        .Run         (run),
        .pc          (pc),
        .busy        (busy),
        .finished    (finished),
        .timeout_err (timeout_err),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mem_sh [16];

    // Proc stub: Done on the stub_delay-th cycle of each Run, plus a manual override
    int   stub_delay = 3;
    logic stub_en    = 1'b0;
    logic done_force = 1'b0;
    int   run_cnt    = 0;
    always @(posedge clk) run_cnt <= run ? run_cnt + 1 : 0;
    assign done = done_force | (stub_en & run & (run_cnt == stub_delay - 1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard on handshakes, Run-high length and inter-instruction gap length
    int run_len = 0, last_run_len = 0, low_cnt = 0;
    always @(negedge clk) begin
        if (run && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_issue observed=%0h expected=none", din);
            end else begin
                chk("din", 32'(din), 32'(exp_q.pop_front()));
            end
        end
        if (run) run_len++;
        else begin
            if (run_len != 0) last_run_len = run_len;
            run_len = 0;
        end
        if (busy && !run) low_cnt++;
        else begin
            if (run && low_cnt != 0) chk("gap_len", 32'(low_cnt), 32'd1);
            low_cnt = 0;
        end
    end

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len);
        @(negedge clk);
        prog_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_prog(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem_sh[i % 16]);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_bound", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; prog_len = '0;
        mem_sh[0] = 16'h101C; mem_sh[1] = 16'h32FF; mem_sh[2] = 16'h52FF;
        mem_sh[3] = 16'h6200; mem_sh[4] = 16'h5201;
        for (int i = 5; i < 16; i++) mem_sh[i] = 16'hA000 + 16'(i);
        repeat (3) @(negedge clk);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_flags", {29'd0, busy, finished, timeout_err}, 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) load(4'(i), mem_sh[i]);

        // 1: five-word program, Done three cycles into each Run
        stub_en = 1'b1; stub_delay = 3;
        push_prog(5);
        do_start(5'd5);
        chk("t1_run_rise", 32'(run), 32'd1);
        chk("t1_din0", 32'(din), 32'h101C);
        wait_idle(200);
        chk("t1_finished", 32'(finished), 32'd1);
        chk("t1_count", 32'(instr_count), 32'd5);
        chk("t1_pc", 32'(pc), 32'd5);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_run_len", 32'(last_run_len), 32'd3);

        // 2: no Done -> timeout after exactly 64 Run cycles
        stub_en = 1'b0;
        do_start(5'd5);
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("t2_err", 32'(timeout_err), 32'd1);
        chk("t2_run_len", 32'(last_run_len), 32'd64);
        chk("t2_run", 32'(run), 32'd0);
        chk("t2_pc", 32'(pc), 32'd0);
        stub_en = 1'b1;
        push_prog(1);
        do_start(5'd1);
        chk("t2_err_clear", 32'(timeout_err), 32'd0);
        wait_idle(50);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: Stop during instruction 2 lets it finish, then idles
        push_prog(2);
        do_start(5'd5);
        n = 0;
        while (!(run && instr_count == 16'd1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(50);
        repeat (5) @(negedge clk);
        chk("t3_count", 32'(instr_count), 32'd2);
        chk("t3_run", 32'(run), 32'd0);
        chk("t3_idle", {30'd0, finished, busy}, 32'd0);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
        done_force = 1'b1;
        @(negedge clk);
        done_force = 1'b0;
        @(negedge clk);
        chk("t3_done_idle", 32'(instr_count), 32'd2);

        // 4: empty program, then oversize program clamped to DEPTH with Done on first cycle
        do_start(5'd0);
        chk("t4_len0_fin", 32'(finished), 32'd1);
        chk("t4_len0_run", 32'(run), 32'd0);
        stub_delay = 1;
        push_prog(16);
        do_start(5'd20);
        wait_idle(400);
        chk("t4_fin", 32'(finished), 32'd1);
        chk("t4_pc_wrap", 32'(pc), 32'd0);
        chk("t4_count", 32'(instr_count), 32'd16);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: async reset mid-ISSUE, then rerun with memory intact
        stub_delay = 3;
        push_prog(5);
        do_start(5'd5);
        n = 0;
        while (!(run && instr_count == 16'd2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_run", 32'(run), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_pc", 32'(pc), 32'd0);
        chk("t5_rst_count", 32'(instr_count), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_prog(5);
        do_start(5'd5);
        wait_idle(200);
        chk("t5_count", 32'(instr_count), 32'd5);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // 6: load while busy is ignored; Done during GAP is ignored
        push_prog(5);
        do_start(5'd5);
        load(4'd1, 16'hDEAD);
        n = 0;
        while (!(busy && !run) && n < 50) begin
            @(negedge clk);
            n++;
        end
        done_force = 1'b1;
        @(negedge clk);
        done_force = 1'b0;
        wait_idle(200);
        chk("t6_count", 32'(instr_count), 32'd5);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        push_prog(2);
        do_start(5'd2);
        wait_idle(100);
        chk("t6_mem1_kept", 32'(exp_q.size()), 32'd0);
        chk("t6_fin", 32'(finished), 32'd1);

        // Start and Stop together in FINISH: Stop wins
        @(negedge clk);
        start = 1'b1; stop = 1'b1; prog_len = 5'd5;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("stop_wins_busy", 32'(busy), 32'd0);
        chk("stop_wins_fin", 32'(finished), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
